// File: rtl/des_key_sched.sv
// Sequential DES key schedule: PC-1 on key load, then one PC-2 subkey per valid/ready handshake.
// Define DES_KEYSCHED_DECRYPT_EN to honour the decrypt input (K16..K1 order via right rotations).
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:1] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [48:1] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        last
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Tables use FIPS 46-3 numbering, where bit 1 is the MSB of the vector.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [56:1] p_keyinit(input logic [64:1] k);
        logic [56:1] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            r[56 - i] = k[65 - PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [48:1] p_pc2(input logic [56:1] cd);
        logic [48:1] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            r[48 - i] = cd[57 - PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [28:1] rol(input logic [28:1] x, input logic two);
        return two ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; all others by two.
    function automatic logic shift_is_two(input logic [4:0] rnd);
        return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    function automatic logic [28:1] ror(input logic [28:1] x, input logic two);
        return two ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
    endfunction
`endif

    state_t      state_q, state_d;
    logic [28:1] c_q, c_d;
    logic [28:1] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic [56:1] pc1;
    logic [4:0]  enc_next_rnd;

    assign pc1          = p_keyinit(key);
    assign enc_next_rnd = {1'b0, round_q} + 5'd2;

`ifdef DES_KEYSCHED_DECRYPT_EN
    logic       dec_q, dec_d;
    logic [4:0] dec_next_rnd;

    // Decrypt step i rotates right by the encrypt shift of round 18-i; i = round_q + 2.
    assign dec_next_rnd = 5'd16 - {1'b0, round_q};
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        d_d          = d_q;
        round_d      = round_q;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
        dec_d        = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_d = ST_ISSUE;
                    round_d = '0;
`ifdef DES_KEYSCHED_DECRYPT_EN
                    dec_d = decrypt;
                    if (decrypt) begin
                        c_d = pc1[56:29];
                        d_d = pc1[28:1];
                    end else begin
                        c_d = rol(pc1[56:29], 1'b0);
                        d_d = rol(pc1[28:1], 1'b0);
                    end
`else
                    c_d = rol(pc1[56:29], 1'b0);
                    d_d = rol(pc1[28:1], 1'b0);
`endif
                end
            end
            ST_ISSUE: begin
                subkey_valid = 1'b1;
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
`ifdef DES_KEYSCHED_DECRYPT_EN
                        if (dec_q) begin
                            c_d = ror(c_q, shift_is_two(dec_next_rnd));
                            d_d = ror(d_q, shift_is_two(dec_next_rnd));
                        end else begin
                            c_d = rol(c_q, shift_is_two(enc_next_rnd));
                            d_d = rol(d_q, shift_is_two(enc_next_rnd));
                        end
`else
                        c_d = rol(c_q, shift_is_two(enc_next_rnd));
                        d_d = rol(d_q, shift_is_two(enc_next_rnd));
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
        end
    end

`ifdef DES_KEYSCHED_DECRYPT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    assign subkey = p_pc2({c_q, d_q});
    assign round  = round_q;
    assign last   = (state_q == ST_ISSUE) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized self-checking bench for des_key_sched against a table-driven DES key-schedule model.
// Expectations follow DES_KEYSCHED_DECRYPT_EN when it is defined for the build.
module tb_des_key_sched;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_KNOWN  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_KNOWN = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] exp_sk [16];

    des_key_sched dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .decrypt     (decrypt),
        .subkey      (subkey),
        .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready),
        .round       (round),
        .last        (last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Subkey r uses the PC-1 halves rotated left by the cumulative shift total of rounds 1..r.
    task automatic build_model(input logic [63:0] k, input logic dec);
        bit          kb  [65];
        bit          cd0 [57];
        bit          cd  [57];
        logic [47:0] ks  [16];
        int          rot;
        logic        eff_dec;
`ifdef DES_KEYSCHED_DECRYPT_EN
        eff_dec = dec;
`else
        eff_dec = 1'b0 & dec;
`endif
        for (int n = 1; n <= 64; n++) kb[n] = k[64 - n];
        for (int j = 1; j <= 56; j++) cd0[j] = kb[PC1[j - 1]];
        rot = 0;
        for (int r = 1; r <= 16; r++) begin
            rot += SHIFTS[r - 1];
            for (int j = 1; j <= 28; j++) begin
                cd[j]      = cd0[((j - 1 + rot) % 28) + 1];
                cd[28 + j] = cd0[28 + ((j - 1 + rot) % 28) + 1];
            end
            ks[r - 1] = '0;
            for (int m = 1; m <= 48; m++) ks[r - 1][48 - m] = cd[PC2[m - 1]];
        end
        for (int i = 0; i < 16; i++) exp_sk[i] = eff_dec ? ks[15 - i] : ks[i];
    endtask

    task automatic run_schedule(input logic [63:0] k, input logic dec, input int stall_at,
                                input bit rnd_ready, input bit poke,
                                output logic [47:0] first_sk, output logic [47:0] last_sk);
        int idx;
        int stalled;
        int budget;
        bit rdy;
        build_model(k, dec);
        first_sk = '0;
        last_sk  = '0;
        budget   = 0;
        while (key_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("key_ready_before_load", key_ready, 1);
        key          = k;
        decrypt      = dec;
        key_valid    = 1'b1;
        subkey_ready = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        decrypt   = ~dec;
        key       = {$urandom, $urandom};
        idx     = 0;
        stalled = 0;
        budget  = 0;
        while (idx < 16 && budget < 200) begin
            check_eq($sformatf("subkey_valid[%0d]", idx), subkey_valid, 1);
            check_eq($sformatf("key_ready_busy[%0d]", idx), key_ready, 0);
            check_eq($sformatf("round[%0d]", idx), round, idx);
            check_eq($sformatf("subkey[%0d]", idx), subkey, exp_sk[idx]);
            check_eq($sformatf("last[%0d]", idx), last, (idx == 15));
            if (idx == 0)  first_sk = subkey;
            if (idx == 15) last_sk  = subkey;
            if (idx == stall_at && stalled < 5) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            if (poke && idx == 5) begin
                key       = 64'hFFFFFFFFFFFFFFFF;
                key_valid = 1'b1;
            end
            subkey_ready = rdy;
            @(posedge clk); #1;
            key_valid = 1'b0;
            if (rdy) idx++;
            budget++;
        end
        check_eq("schedule_complete", idx, 16);
        subkey_ready = 1'b0;
        check_eq("valid_after_16", subkey_valid, 0);
        check_eq("key_ready_after_16", key_ready, 1);
    endtask

    initial begin
        logic [47:0] f_sk;
        logic [47:0] l_sk;
        logic        d;

        rst          = 1'b1;
        key          = '0;
        key_valid    = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_key_ready", key_ready, 1);
        check_eq("reset_subkey_valid", subkey_valid, 0);
        check_eq("reset_subkey", subkey, 0);
        check_eq("reset_round", round, 0);
        check_eq("reset_last", last, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_after_reset_ready", key_ready, 1);
        check_eq("idle_after_reset_valid", subkey_valid, 0);

        run_schedule(KNOWN_KEY, 1'b0, -1, 1'b0, 1'b0, f_sk, l_sk);
        check_eq("enc_known_first", f_sk, K1_KNOWN);
        check_eq("enc_known_last", l_sk, K16_KNOWN);

        run_schedule(KNOWN_KEY, 1'b1, -1, 1'b0, 1'b0, f_sk, l_sk);
`ifdef DES_KEYSCHED_DECRYPT_EN
        check_eq("dec_known_first", f_sk, K16_KNOWN);
        check_eq("dec_known_last", l_sk, K1_KNOWN);
`else
        check_eq("dec_ignored_first", f_sk, K1_KNOWN);
        check_eq("dec_ignored_last", l_sk, K16_KNOWN);
`endif

        run_schedule(KNOWN_KEY, 1'b0, 3, 1'b0, 1'b0, f_sk, l_sk);
        check_eq("stall_first", f_sk, K1_KNOWN);
        check_eq("stall_last", l_sk, K16_KNOWN);

        run_schedule(KNOWN_KEY, 1'b0, -1, 1'b1, 1'b1, f_sk, l_sk);
        check_eq("busy_first", f_sk, K1_KNOWN);
        check_eq("busy_last", l_sk, K16_KNOWN);

        for (int t = 0; t < 16; t++) begin
            d = 1'($urandom_range(0, 1));
            run_schedule({$urandom, $urandom}, d, (t % 4 == 0) ? 7 : -1, 1'b1, (t % 3 == 0), f_sk, l_sk);
        end

        // Asynchronous reset in the middle of a schedule, between clock edges.
        key          = KNOWN_KEY;
        decrypt      = 1'b0;
        key_valid    = 1'b1;
        @(posedge clk); #1;
        key_valid    = 1'b0;
        subkey_ready = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_key_ready", key_ready, 1);
        check_eq("midrst_subkey_valid", subkey_valid, 0);
        check_eq("midrst_subkey", subkey, 0);
        check_eq("midrst_round", round, 0);
        check_eq("midrst_last", last, 0);
        subkey_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_midrst_ready", key_ready, 1);
        check_eq("post_midrst_valid", subkey_valid, 0);

        run_schedule(KNOWN_KEY, 1'b0, -1, 1'b0, 1'b0, f_sk, l_sk);
        check_eq("recover_first", f_sk, K1_KNOWN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
